// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_if
// Brief    : Issue handshake, write-back port and ALU-side issue bundle
// Revision : 1.0
// ============================================================================
interface operand_fetch_if;
  logic [31:0] Instruction;
  logic        InValid;
  logic        InReady;
  logic        WriteEnable;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [31:0] DR1;
  logic [31:0] DR2;
  logic [2:0]  ALUControl;
  logic [4:0]  DestReg;
  logic        IllegalOp;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] IssueCount;

  // Driven by upstream/write-back/ALU side
  modport master (
    output Instruction, InValid, WriteEnable, WriteAddr, WriteData, OutReady,
    input  InReady, DR1, DR2, ALUControl, DestReg, IllegalOp, OutValid, IssueCount
  );

  // Implemented by operand_fetch
  modport slave (
    input  Instruction, InValid, WriteEnable, WriteAddr, WriteData, OutReady,
    output InReady, DR1, DR2, ALUControl, DestReg, IllegalOp, OutValid, IssueCount
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Brief    : Register file read, funct decode and one-entry issue buffer
// Revision : 1.0
// ============================================================================
module operand_fetch (
  input logic            clk,
  input logic            rst,
  operand_fetch_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_regs [32];
  logic [31:0] r_dr1;
  logic [31:0] r_dr2;
  logic [2:0]  r_alu_ctrl;
  logic [4:0]  r_dest;
  logic        r_illegal;
  logic [15:0] r_issue_count;

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic        w_out_valid;
  logic        w_accept;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [2:0]  w_alu_ctrl;
  logic        w_illegal;
  logic        w_unused;

  assign w_rs    = bus.Instruction[25:21];
  assign w_rt    = bus.Instruction[20:16];
  assign w_rd    = bus.Instruction[15:11];
  assign w_funct = bus.Instruction[5:0];
  assign w_unused = ^{bus.Instruction[31:26], bus.Instruction[10:6]};

  assign w_out_valid = (r_state == ST_FULL);
  assign w_accept    = bus.InValid && bus.InReady;

  // Handshake state
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (bus.OutReady && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Register file; R0 is never written so it stays zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (bus.WriteEnable && (bus.WriteAddr != 5'd0)) begin
      r_regs[bus.WriteAddr] <= bus.WriteData;
    end
  end

  // Read ports with same-cycle write-back forwarding
  always_comb begin
    w_rs_val = r_regs[w_rs];
    w_rt_val = r_regs[w_rt];
    if (w_rs == 5'd0)
      w_rs_val = '0;
    else if (bus.WriteEnable && (bus.WriteAddr == w_rs))
      w_rs_val = bus.WriteData;
    if (w_rt == 5'd0)
      w_rt_val = '0;
    else if (bus.WriteEnable && (bus.WriteAddr == w_rt))
      w_rt_val = bus.WriteData;
  end

  always_comb begin
    w_alu_ctrl = 3'b000;
    w_illegal  = 1'b0;
    case (w_funct)
      6'h20:   w_alu_ctrl = 3'b001;
      6'h22:   w_alu_ctrl = 3'b010;
      6'h2A:   w_alu_ctrl = 3'b011;
      6'h24:   w_alu_ctrl = 3'b100;
      6'h25:   w_alu_ctrl = 3'b101;
      6'h26:   w_alu_ctrl = 3'b110;
      6'h27:   w_alu_ctrl = 3'b111;
      default: w_illegal  = 1'b1;
    endcase
  end

  // Issue registers only change on accept, so a stalled FULL entry is stable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dr1         <= '0;
      r_dr2         <= '0;
      r_alu_ctrl    <= '0;
      r_dest        <= '0;
      r_illegal     <= 1'b0;
      r_issue_count <= '0;
    end else if (w_accept) begin
      r_dr1         <= w_rs_val;
      r_dr2         <= w_rt_val;
      r_alu_ctrl    <= w_alu_ctrl;
      r_dest        <= w_rd;
      r_illegal     <= w_illegal;
      r_issue_count <= r_issue_count + 16'd1;
    end
  end

  assign bus.InReady    = !w_out_valid || bus.OutReady;
  assign bus.OutValid   = w_out_valid;
  assign bus.DR1        = r_dr1;
  assign bus.DR2        = r_dr2;
  assign bus.ALUControl = r_alu_ctrl;
  assign bus.DestReg    = r_dest;
  assign bus.IllegalOp  = r_illegal;
  assign bus.IssueCount = r_issue_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Brief    : Directed self-checking bench for operand_fetch
// Revision : 1.0
// ============================================================================
module tb_operand_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [15:0] exp_count;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.WriteEnable = 1'b1;
    bus.WriteAddr   = a;
    bus.WriteData   = d;
    tick();
    bus.WriteEnable = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.InValid = 1'b1;
    bus.Instruction = mk(5'd1, 5'd2, 5'd3, 6'h20);
    bus.WriteEnable = 1'b1;
    bus.WriteAddr = 5'd1;
    bus.WriteData = 32'hFFFF_FFFF;
    tick();
    tick();
    rst = 1'b0;
    bus.InValid = 1'b0;
    bus.WriteEnable = 1'b0;
    exp_count = 16'd0;
    #1;
    n_checks++;
    if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid); end
    n_checks++;
    if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b want 1", bus.InReady); end
    n_checks++;
    if ({bus.DR1, bus.DR2, bus.ALUControl, bus.DestReg, bus.IllegalOp, bus.IssueCount} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: DR1=%h DR2=%h ALU=%b Dest=%0d Ill=%b Cnt=%0d want all 0",
                         bus.DR1, bus.DR2, bus.ALUControl, bus.DestReg, bus.IllegalOp, bus.IssueCount);
    end
    // Register 1 must not have taken the write attempted during reset
    bus.Instruction = mk(5'd1, 5'd0, 5'd0, 6'h20);
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    exp_count++;
    n_checks++;
    if (bus.DR1 !== 32'd0) begin n_fail++; $display("FAIL reset_write_ignored: got %h want 0", bus.DR1); end
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
  endtask

  task automatic test_add();
    write_reg(5'd5, 32'd7);
    write_reg(5'd6, 32'd3);
    bus.Instruction = mk(5'd5, 5'd6, 5'd7, 6'h20);
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    bus.Instruction = 32'hFFFF_FFFF;
    exp_count++;
    n_checks++;
    if (bus.OutValid !== 1'b1) begin n_fail++; $display("FAIL add_outvalid: got %b want 1", bus.OutValid); end
    n_checks++;
    if (bus.DR1 !== 32'd7 || bus.DR2 !== 32'd3) begin
      n_fail++; $display("FAIL add_operands: got %h/%h want 7/3", bus.DR1, bus.DR2);
    end
    n_checks++;
    if (bus.ALUControl !== 3'b001 || bus.DestReg !== 5'd7 || bus.IllegalOp !== 1'b0) begin
      n_fail++; $display("FAIL add_decode: got alu=%b dest=%0d ill=%b want 001/7/0",
                         bus.ALUControl, bus.DestReg, bus.IllegalOp);
    end
    n_checks++;
    if (bus.IssueCount !== exp_count) begin n_fail++; $display("FAIL add_count: got %0d want %0d", bus.IssueCount, exp_count); end
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
    n_checks++;
    if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b want 0", bus.OutValid); end
  endtask

  task automatic test_bypass();
    bus.Instruction = mk(5'd5, 5'd5, 5'd1, 6'h22);
    bus.InValid = 1'b1;
    bus.WriteEnable = 1'b1;
    bus.WriteAddr = 5'd5;
    bus.WriteData = 32'hDEAD_BEEF;
    tick();
    bus.InValid = 1'b0;
    bus.WriteEnable = 1'b0;
    exp_count++;
    n_checks++;
    if (bus.DR1 !== 32'hDEAD_BEEF || bus.DR2 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass_rs_rt: got %h/%h want deadbeef/deadbeef", bus.DR1, bus.DR2);
    end
    // A later write to the held source must not disturb the issue
    write_reg(5'd5, 32'h1234_5678);
    n_checks++;
    if (bus.DR1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL held_no_update: got %h want deadbeef", bus.DR1); end
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
    bus.Instruction = mk(5'd0, 5'd6, 5'd2, 6'h20);
    bus.InValid = 1'b1;
    bus.WriteEnable = 1'b1;
    bus.WriteAddr = 5'd0;
    bus.WriteData = 32'hDEAD_BEEF;
    tick();
    bus.InValid = 1'b0;
    bus.WriteEnable = 1'b0;
    exp_count++;
    n_checks++;
    if (bus.DR1 !== 32'd0 || bus.DR2 !== 32'd3) begin
      n_fail++; $display("FAIL bypass_r0: got %h/%h want 0/3", bus.DR1, bus.DR2);
    end
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
  endtask

  task automatic test_stall();
    bus.Instruction = mk(5'd5, 5'd6, 5'd3, 6'h24);
    bus.InValid = 1'b1;
    tick();
    exp_count++;
    bus.Instruction = mk(5'd6, 5'd5, 5'd4, 6'h25);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.InReady !== 1'b0) begin n_fail++; $display("FAIL stall_inready[%0d]: got %b want 0", i, bus.InReady); end
      tick();
      n_checks++;
      if (bus.OutValid !== 1'b1 || bus.DR1 !== 32'h1234_5678 || bus.DR2 !== 32'd3 ||
          bus.ALUControl !== 3'b100 || bus.DestReg !== 5'd3 || bus.IssueCount !== exp_count) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h/%h alu=%b d=%0d c=%0d want 1 12345678/3 100 3 %0d",
                           i, bus.OutValid, bus.DR1, bus.DR2, bus.ALUControl, bus.DestReg, bus.IssueCount, exp_count);
      end
    end
    bus.OutReady = 1'b1;
    #1;
    n_checks++;
    if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL stall_release_inready: got %b want 1", bus.InReady); end
    tick();
    bus.InValid = 1'b0;
    exp_count++;
    n_checks++;
    if (bus.DR1 !== 32'd3 || bus.DR2 !== 32'h1234_5678 || bus.ALUControl !== 3'b101 ||
        bus.DestReg !== 5'd4 || bus.IssueCount !== exp_count) begin
      n_fail++; $display("FAIL stall_release: got %h/%h alu=%b d=%0d c=%0d want 3/12345678 101 4 %0d",
                         bus.DR1, bus.DR2, bus.ALUControl, bus.DestReg, bus.IssueCount, exp_count);
    end
    tick();
    n_checks++;
    if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL stall_drain: got %b want 0", bus.OutValid); end
    bus.OutReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  fn  [4];
    logic [2:0]  alu [4];
    fn  = '{6'h20, 6'h22, 6'h2A, 6'h26};
    alu = '{3'b001, 3'b010, 3'b011, 3'b110};
    do_reset();
    write_reg(5'd1, 32'd10);
    write_reg(5'd2, 32'd20);
    bus.OutReady = 1'b1;
    bus.InValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Instruction = mk(5'd1, 5'd2, 5'(11 + i), fn[i]);
      tick();
      n_checks++;
      if (bus.OutValid !== 1'b1 || bus.DestReg !== 5'(11 + i) || bus.ALUControl !== alu[i] ||
          bus.DR1 !== 32'd10 || bus.DR2 !== 32'd20) begin
        n_fail++; $display("FAIL b2b[%0d]: got v=%b d=%0d alu=%b %0d/%0d want 1 %0d %b 10/20",
                           i, bus.OutValid, bus.DestReg, bus.ALUControl, bus.DR1, bus.DR2, 11 + i, alu[i]);
      end
    end
    bus.InValid = 1'b0;
    n_checks++;
    if (bus.IssueCount !== 16'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", bus.IssueCount); end
    tick();
    bus.OutReady = 1'b0;
  endtask

  task automatic test_decode();
    logic [5:0] fn  [9];
    logic [3:0] exp [9];
    fn  = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h21};
    exp = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1000};
    bus.OutReady = 1'b1;
    bus.InValid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.Instruction = mk(5'd0, 5'd0, 5'd0, fn[i]);
      tick();
      n_checks++;
      if ({bus.IllegalOp, bus.ALUControl} !== exp[i] || bus.DestReg !== 5'd0) begin
        n_fail++; $display("FAIL decode_funct_%h: got ill=%b alu=%b d=%0d want ill=%b alu=%b d=0",
                           fn[i], bus.IllegalOp, bus.ALUControl, bus.DestReg, exp[i][3], exp[i][2:0]);
      end
    end
    bus.InValid = 1'b0;
    tick();
    bus.OutReady = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bus.OutReady = 1'b1;
    bus.InValid = 1'b1;
    bus.Instruction = mk(5'd0, 5'd0, 5'd0, 6'h20);
    repeat (65535) tick();
    n_checks++;
    if (bus.IssueCount !== 16'hFFFF) begin n_fail++; $display("FAIL count_ffff: got %h want ffff", bus.IssueCount); end
    tick();
    n_checks++;
    if (bus.IssueCount !== 16'h0000) begin n_fail++; $display("FAIL count_wrap: got %h want 0000", bus.IssueCount); end
    bus.InValid = 1'b0;
    tick();
    bus.OutReady = 1'b0;
    write_reg(5'd5, 32'd7);
    write_reg(5'd6, 32'd3);
    bus.Instruction = mk(5'd5, 5'd6, 5'd7, 6'h00);
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    n_checks++;
    if (bus.OutValid !== 1'b1 || bus.DR1 !== 32'd7 || bus.IllegalOp !== 1'b1) begin
      n_fail++; $display("FAIL prereset_full: got v=%b dr1=%h ill=%b want 1 7 1", bus.OutValid, bus.DR1, bus.IllegalOp);
    end
    do_reset();
    n_checks++;
    if ({bus.OutValid, bus.DR1, bus.DR2, bus.ALUControl, bus.DestReg, bus.IllegalOp, bus.IssueCount} !== '0) begin
      n_fail++; $display("FAIL reset_full: v=%b %h/%h alu=%b d=%0d ill=%b c=%0d want all 0",
                         bus.OutValid, bus.DR1, bus.DR2, bus.ALUControl, bus.DestReg, bus.IllegalOp, bus.IssueCount);
    end
    bus.Instruction = mk(5'd5, 5'd6, 5'd8, 6'h2A);
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    n_checks++;
    if (bus.DR1 !== 32'd0 || bus.DR2 !== 32'd0 || bus.DestReg !== 5'd8 ||
        bus.ALUControl !== 3'b011 || bus.IssueCount !== 16'd1) begin
      n_fail++; $display("FAIL regs_cleared: got %h/%h d=%0d alu=%b c=%0d want 0/0 8 011 1",
                         bus.DR1, bus.DR2, bus.DestReg, bus.ALUControl, bus.IssueCount);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_count = 16'd0;
    rst = 1'b1;
    bus.Instruction = '0;
    bus.InValid = 1'b0;
    bus.WriteEnable = 1'b0;
    bus.WriteAddr = '0;
    bus.WriteData = '0;
    bus.OutReady = 1'b0;
    test_reset();
    test_add();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_decode();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
